operand_loader: RTL
===================

Name: operand_loader

Overview:
Upstream front end of the 8-bit lab adder: turns two raw slide switches and one raw push key into two debounced, bit-serially assembled 8-bit operands. Each debounced press of key k0 captures one bit from each switch, LSB first. After the 8th press, both operands are presented together for one cycle (valid pulse). The adder/LED stage consumes them.

Parameters:
DB_CYCLES, 250000, consecutive stable cycles before the debounced key level changes (5 ms at 50 MHz); must be >= 2; benches override to 4
NBITS, 8, operand width and number of presses per word

Ports:
clk    in   1      system clock, all logic on rising edge
k1     in   1      synchronous active-low reset (key 1)
s0     in   1      raw switch, serial bit source for operand b
s1     in   1      raw switch, serial bit source for operand a
k0     in   1      raw push key, active-low (0 = pressed), asynchronous, bouncy
a      out  NBITS  assembled operand a (from s1)
b      out  NBITS  assembled operand b (from s0)
valid  out  1      one-cycle pulse; a/b just updated with a complete word
count  out  4      bits captured in the current word, 0..NBITS-1
busy   out  1      1 when count != 0 (partial word in progress)

Behaviour:
- Reset: k1 sampled 0 at a clk edge applies reset. Only the synchronous form exists; there is no asynchronous reset path.
- Reset values:
  - a = 0, b = 0, valid = 0, count = 0, busy = 0.
  - Internal shift registers = 0.
  - Sync flops for k0/s0/s1 = 1/0/0.
  - Debounced key level = 1 (released); debounce counter = 0.
- Synchronisers:
  - k0, s0 and s1 each pass through a 2-flop synchroniser.
  - All later logic uses only the synchronised values (k0_s, s0_s, s1_s).
- Debounce:
  - Counter increments each cycle while k0_s != deb.
  - Counter clears to 0 in any cycle where k0_s == deb.
  - When the counter equals DB_CYCLES-1 and k0_s still differs, deb <= k0_s and the counter clears.
  - Result: deb changes exactly DB_CYCLES cycles after k0_s settles. Any glitch shorter than DB_CYCLES cycles is ignored.
- Press event:
  - Single-cycle internal strobe on a deb 1->0 transition.
  - A release (0->1) produces no event.
  - Holding the key produces exactly one event.
- Capture on press event, same edge, with i = count:
  - sh_a[i] <= s1_s, sh_b[i] <= s0_s.
  - If count < NBITS-1: count <= count+1.
  - If count == NBITS-1 (completing press):
    - a <= {s1_s, sh_a[NBITS-2:0]}, b <= {s0_s, sh_b[NBITS-2:0]}.
    - valid <= 1, count <= 0, shift registers cleared.
- Latency from the first clk edge sampling k0=0 (stable) to the press event: 2 + DB_CYCLES cycles. On the completing press, a, b and valid update at the edge after the press event.
- valid:
  - High exactly one cycle per completed word; low otherwise.
  - Never high two cycles in a row, since press events are at least 2*DB_CYCLES apart.
- a and b hold their last complete word until the next completion. Partial words are never visible on a/b.
- Switch changes between presses have no effect. Only the value at the press-event cycle is captured.
- Reset during a partial word: partial bits are discarded, count = 0, and a/b return to 0.
- Reset while the key is held: deb = 1 after reset, so the still-held key produces a new press event after DB_CYCLES cycles. This is required behaviour.
- Reset and a press event in the same cycle: reset wins, and nothing is captured.
- Width: count is 4 bits for NBITS = 8 and wraps 7 -> 0 only via completion.

Test Plan (DB_CYCLES = 4):
- Reset: hold k1=0 for 3 cycles with k0 toggling -> a=0, b=0, valid=0, count=0, busy=0 throughout.
- Clean word: 8 clean presses (k0 low 10 cycles, high 10 cycles), s1 bits LSB first = 1,0,1,0,0,1,0,1 and s0 = all 1 -> a=8'hA5, b=8'hFF; valid high exactly 1 cycle after the 8th press; count returns to 0.
- Bounce: each press preceded by k0 pulses 1-3 cycles wide; 8 real presses with s1 = 1, s0 = 0 throughout -> exactly 8 events; a=8'hFF, b=8'h00; one valid pulse.
- Long hold plus switch changes: hold k0 low 50 cycles while toggling s0/s1 after the event -> count advances by exactly 1, and the bits captured are the values at the event cycle.
- Mid-word reset: 5 presses, then k1=0 for 1 cycle, then 8 presses with s1 pattern giving 8'h3C -> a=8'h3C (no stale bits); only 1 valid pulse, after reset.
- Back-to-back words: 16 presses with a=01,b=80 then a=FE,b=7F -> two valid pulses; a/b show 01/80 between them, then FE/7F; a/b stable during the second partial word.

Source files
------------

// File: rtl/operand_loader_if.sv
// ============================================================================
//  Module   : operand_loader_if
//  Brief    : Switch/key inputs and assembled-operand outputs of operand_loader
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface operand_loader_if #(
  parameter int NBITS = 8
);
  logic             k0;
  logic             s0;
  logic             s1;
  logic [NBITS-1:0] a;
  logic [NBITS-1:0] b;
  logic             valid;
  logic [3:0]       count;
  logic             busy;

  modport master (
    output k0, s0, s1,
    input  a, b, valid, count, busy
  );

  modport slave (
    input  k0, s0, s1,
    output a, b, valid, count, busy
  );
endinterface

`default_nettype wire

// File: rtl/operand_loader.sv
// ============================================================================
//  Module   : operand_loader
//  Brief    : Debounced key press captures one bit per switch, LSB first,
//             and publishes two NBITS-wide operands with a one-cycle valid.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module operand_loader #(
  parameter int DB_CYCLES = 250000,
  parameter int NBITS     = 8
) (
  input  logic             clk,
  input  logic             k1,
  operand_loader_if.slave  bus
);

  localparam int              CNT_W      = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam int              IDX_W      = $clog2(NBITS);
  localparam logic [CNT_W-1:0] c_DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [3:0]       c_CNT_LAST = 4'(NBITS - 1);

  logic             r_k0_m, r_k0_s;
  logic             r_s0_m, r_s0_s;
  logic             r_s1_m, r_s1_s;
  logic             r_deb, r_deb_d;
  logic [CNT_W-1:0] r_db_cnt;
  logic [NBITS-2:0] r_sh_a, r_sh_b;
  logic [NBITS-1:0] r_a, r_b;
  logic             r_valid;
  logic [3:0]       r_count;

  logic             w_press;
  logic [IDX_W-1:0] w_idx;

  // Press strobe: debounced level has just fallen (release edges are ignored)
  assign w_press = r_deb_d & ~r_deb;
  assign w_idx   = r_count[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (!k1) begin
      r_k0_m   <= 1'b1;
      r_k0_s   <= 1'b1;
      r_s0_m   <= 1'b0;
      r_s0_s   <= 1'b0;
      r_s1_m   <= 1'b0;
      r_s1_s   <= 1'b0;
      r_deb    <= 1'b1;
      r_deb_d  <= 1'b1;
      r_db_cnt <= '0;
      r_sh_a   <= '0;
      r_sh_b   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_valid  <= 1'b0;
      r_count  <= '0;
    end else begin
      r_k0_m  <= bus.k0;
      r_k0_s  <= r_k0_m;
      r_s0_m  <= bus.s0;
      r_s0_s  <= r_s0_m;
      r_s1_m  <= bus.s1;
      r_s1_s  <= r_s1_m;
      r_deb_d <= r_deb;

      if (r_k0_s == r_deb) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == c_DB_LAST) begin
        r_deb    <= r_k0_s;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end

      r_valid <= 1'b0;
      if (w_press) begin
        if (r_count == c_CNT_LAST) begin
          r_a     <= {r_s1_s, r_sh_a};
          r_b     <= {r_s0_s, r_sh_b};
          r_valid <= 1'b1;
          r_count <= '0;
          r_sh_a  <= '0;
          r_sh_b  <= '0;
        end else begin
          r_sh_a[w_idx] <= r_s1_s;
          r_sh_b[w_idx] <= r_s0_s;
          r_count       <= r_count + 1'b1;
        end
      end
    end
  end

  assign bus.a     = r_a;
  assign bus.b     = r_b;
  assign bus.valid = r_valid;
  assign bus.count = r_count;
  assign bus.busy  = (r_count != 4'd0);

endmodule

`default_nettype wire
